exec_sequencer: RTL and testbench



---
 rtl/exec_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle execute/control stage sitting in front of a 16x16-bit
//   register file. It takes one instruction per handshake and walks it
//   through IDLE -> READ -> EXEC -> WRITE. Writeback finishes before the
//   next read, so the stage never has hazards.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake (ready only in IDLE)
//   instr[15:0]                {opcode, dest, srcA, srcB}
//   rf_a_sel, rf_b_sel         register file read selects
//   rf_a, rf_b                 register file read data (combinational)
//   rf_dest_sel, rf_load_en,
//   rf_d                       register file write port
//   flag_z, flag_c, flag_n     zero / carry-borrow / negative flags
//   retired                    one-cycle pulse when an instruction completes
//   illegal                    one-cycle pulse on an undefined opcode
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | instr_ready high, waiting for a handshake
// READ   | read selects driven, operands captured at end of cycle
// EXEC   | ALU result and flags registered; NOP/CMP/illegal pulse here
// WRITE  | rf_load_en high, result written on the edge ending the cycle

module exec_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_a_sel,
  output logic [3:0]  rf_b_sel,
  input  logic [15:0] rf_a,
  input  logic [15:0] rf_b,
  output logic [3:0]  rf_dest_sel,
  output logic        rf_load_en,
  output logic [15:0] rf_d,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_n,
  output logic        retired,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        instr_ready_q, instr_ready_d;
  logic [3:0]  rf_a_sel_q, rf_a_sel_d;
  logic [3:0]  rf_b_sel_q, rf_b_sel_d;
  logic [3:0]  rf_dest_sel_q, rf_dest_sel_d;
  logic        rf_load_en_q, rf_load_en_d;
  logic [15:0] rf_d_q, rf_d_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_n_q, flag_n_d;
  logic        retired_q, retired_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  op;
  logic        op_writes;
  logic        op_illegal;
  logic [16:0] sum;
  logic [15:0] alu_res;
  logic        alu_c;
  logic        alu_upd;

  assign op         = instr_q[15:12];
  // ADD..MOV are exactly the opcodes that write the destination.
  assign op_writes  = (op >= OP_ADD) && (op <= OP_MOV);
  assign op_illegal = (op > OP_CMP);

  always_comb begin
    sum     = {1'b0, op_a_q} + {1'b0, op_b_q};
    alu_res = 16'h0000;
    alu_c   = 1'b0;
    alu_upd = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[15:0];
        alu_c   = sum[16];
        alu_upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = op_a_q - op_b_q;
        alu_c   = (op_a_q < op_b_q);
        alu_upd = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a_q & op_b_q;
        alu_upd = 1'b1;
      end
      OP_OR: begin
        alu_res = op_a_q | op_b_q;
        alu_upd = 1'b1;
      end
      OP_XOR: begin
        alu_res = op_a_q ^ op_b_q;
        alu_upd = 1'b1;
      end
      OP_SHL: begin
        alu_res = op_a_q << op_b_q[3:0];
        alu_upd = 1'b1;
      end
      OP_SHR: begin
        alu_res = op_a_q >> op_b_q[3:0];
        alu_upd = 1'b1;
      end
      OP_LDI:  alu_res = {{8{instr_q[7]}}, instr_q[7:0]};
      OP_MOV:  alu_res = op_a_q;
      default: alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    instr_ready_d = instr_ready_q;
    rf_a_sel_d    = rf_a_sel_q;
    rf_b_sel_d    = rf_b_sel_q;
    rf_dest_sel_d = rf_dest_sel_q;
    rf_load_en_d  = 1'b0;
    rf_d_d        = rf_d_q;
    flag_z_d      = flag_z_q;
    flag_c_d      = flag_c_q;
    flag_n_d      = flag_n_q;
    retired_d     = 1'b0;
    illegal_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          instr_d       = instr;
          // Selects come straight from the handshake so they are stable
          // for the whole READ cycle.
          rf_a_sel_d    = instr[7:4];
          rf_b_sel_d    = instr[3:0];
          instr_ready_d = 1'b0;
          state_d       = S_READ;
        end
      end
      S_READ: begin
        op_a_d  = rf_a;
        op_b_d  = rf_b;
        state_d = S_EXEC;
        // Non-writing opcodes finish in EXEC, so their pulse is armed here.
        if (!op_writes) begin
          retired_d = !op_illegal;
          illegal_d = op_illegal;
        end
      end
      S_EXEC: begin
        if (alu_upd) begin
          flag_z_d = (alu_res == 16'h0000);
          flag_c_d = alu_c;
          flag_n_d = alu_res[15];
        end
        if (op_writes) begin
          rf_d_d        = alu_res;
          rf_dest_sel_d = instr_q[11:8];
          rf_load_en_d  = 1'b1;
          retired_d     = 1'b1;
          state_d       = S_WRITE;
        end else begin
          instr_ready_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WRITE: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= 16'h0000;
      op_a_q        <= 16'h0000;
      op_b_q        <= 16'h0000;
      instr_ready_q <= 1'b1;
      rf_a_sel_q    <= 4'h0;
      rf_b_sel_q    <= 4'h0;
      rf_dest_sel_q <= 4'h0;
      rf_load_en_q  <= 1'b0;
      rf_d_q        <= 16'h0000;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      flag_n_q      <= 1'b0;
      retired_q     <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      instr_ready_q <= instr_ready_d;
      rf_a_sel_q    <= rf_a_sel_d;
      rf_b_sel_q    <= rf_b_sel_d;
      rf_dest_sel_q <= rf_dest_sel_d;
      rf_load_en_q  <= rf_load_en_d;
      rf_d_q        <= rf_d_d;
      flag_z_q      <= flag_z_d;
      flag_c_q      <= flag_c_d;
      flag_n_q      <= flag_n_d;
      retired_q     <= retired_d;
      illegal_q     <= illegal_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign rf_a_sel    = rf_a_sel_q;
  assign rf_b_sel    = rf_b_sel_q;
  assign rf_dest_sel = rf_dest_sel_q;
  assign rf_load_en  = rf_load_en_q;
  assign rf_d        = rf_d_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign flag_n      = flag_n_q;
  assign retired     = retired_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a behavioural register file drives the DUT, and
// a spec-level model predicts every output for every cycle.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [3:0]  rf_a_sel, rf_b_sel, rf_dest_sel;
  logic [15:0] rf_a, rf_b, rf_d;
  logic        rf_load_en, flag_z, flag_c, flag_n, retired, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel), .rf_a(rf_a), .rf_b(rf_b),
    .rf_dest_sel(rf_dest_sel), .rf_load_en(rf_load_en), .rf_d(rf_d),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .retired(retired), .illegal(illegal)
  );

  // Register file seen by the DUT.
  logic [15:0] rf_mem [16];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h0000;
    end else if (rf_load_en) begin
      rf_mem[rf_dest_sel] <= rf_d;
    end
  end
  assign rf_a = rf_mem[rf_a_sel];
  assign rf_b = rf_mem[rf_b_sel];

  // Model: expected outputs for the current cycle plus in-flight instruction.
  logic [15:0] mreg [16];
  logic        m_ready, m_le, m_z, m_c, m_n, m_ret, m_ill;
  logic [3:0]  m_a_sel, m_b_sel, m_dest;
  logic [15:0] m_d;
  int          m_age;        // cycles since the accepting edge, 0 = nothing in flight
  logic [15:0] f_ins, f_res;
  logic        f_c;
  bit          f_upd, f_wr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_alu(input logic [15:0] ins, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] res,
                                    output logic c, output bit upd, output bit wr);
    int unsigned ua, ub, s;
    int op;
    ua = a; ub = b; op = ins[15:12];
    res = 16'h0000; c = 1'b0; upd = 0; wr = 0;
    case (op)
      1: begin s = ua + ub; res = s[15:0]; c = (s > 65535); upd = 1; wr = 1; end
      2, 10: begin s = (ua + 65536 - ub) % 65536; res = s[15:0]; c = (ua < ub);
                   upd = 1; wr = (op == 2); end
      3: begin res = a & b; upd = 1; wr = 1; end
      4: begin res = a | b; upd = 1; wr = 1; end
      5: begin res = a ^ b; upd = 1; wr = 1; end
      6: begin s = (ua << (ub % 16)) % 65536; res = s[15:0]; upd = 1; wr = 1; end
      7: begin s = ua >> (ub % 16); res = s[15:0]; upd = 1; wr = 1; end
      8: begin s = ins[7] ? (32'hFF00 + ins[7:0]) : ins[7:0]; res = s[15:0]; wr = 1; end
      9: begin res = a; wr = 1; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_ready = 1; m_le = 0; m_z = 0; m_c = 0; m_n = 0; m_ret = 0; m_ill = 0;
    m_a_sel = 0; m_b_sel = 0; m_dest = 0; m_d = 0; m_age = 0;
  endtask

  // Predict the next cycle given the inputs presented at the coming edge.
  task automatic model_advance(input logic v, input logic [15:0] ins, input logic r);
    int op;
    if (!r) begin model_reset(); return; end
    m_ret = 0; m_ill = 0;
    op = f_ins[15:12];
    if (m_age == 0) begin
      if (v && m_ready) begin
        f_ins = ins;
        model_alu(ins, mreg[ins[7:4]], mreg[ins[3:0]], f_res, f_c, f_upd, f_wr);
        m_ready = 0; m_a_sel = ins[7:4]; m_b_sel = ins[3:0]; m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      if (!f_wr) begin
        m_ill = (op >= 11);
        m_ret = (op < 11);
      end
    end else if (m_age == 2) begin
      if (f_upd) begin m_z = (f_res == 0); m_c = f_c; m_n = f_res[15]; end
      if (f_wr) begin
        m_le = 1; m_dest = f_ins[11:8]; m_d = f_res; m_ret = 1; m_age = 3;
      end else begin
        m_ready = 1; m_age = 0;
      end
    end else begin
      m_le = 0; mreg[f_ins[11:8]] = f_res; m_ready = 1; m_age = 0;
    end
  endtask

  task automatic compare_all();
    chk("instr_ready", {15'd0, instr_ready}, {15'd0, m_ready});
    chk("rf_a_sel", {12'd0, rf_a_sel}, {12'd0, m_a_sel});
    chk("rf_b_sel", {12'd0, rf_b_sel}, {12'd0, m_b_sel});
    chk("rf_load_en", {15'd0, rf_load_en}, {15'd0, m_le});
    chk("rf_dest_sel", {12'd0, rf_dest_sel}, {12'd0, m_dest});
    chk("rf_d", rf_d, m_d);
    chk("flags", {13'd0, flag_z, flag_c, flag_n}, {13'd0, m_z, m_c, m_n});
    chk("retired", {15'd0, retired}, {15'd0, m_ret});
    chk("illegal", {15'd0, illegal}, {15'd0, m_ill});
  endtask

  // One cycle: drive at the falling edge, then check just after the rising edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic r);
    logic was_rst;
    @(negedge clk);
    was_rst = rst_n;
    rst_n = r; instr_valid = v; instr = ins;
    if (was_rst && !r) begin
      #1;
      chk("async_rst_load_en", {15'd0, rf_load_en}, 16'd0);
      chk("async_rst_ready", {15'd0, instr_ready}, 16'd1);
    end
    model_advance(v, ins, r);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'($urandom), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
    f_ins = 0; f_res = 0; f_c = 0; f_upd = 0; f_wr = 0;
    model_reset();
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    mem_clr = 1'b0;
    chk("reset_ready", {15'd0, instr_ready}, 16'd1);
    chk("reset_outputs", {rf_load_en, retired, illegal, flag_z, flag_c, flag_n, rf_d[9:0]}, 16'd0);
    step(0, 16'h0000, 1);

    // LDI r3,0xFF: write visible three cycles after the handshake.
    step(1, 16'h83FF, 1);
    idle(2);
    chk("ldi_load_en", {15'd0, rf_load_en}, 16'd1);
    chk("ldi_dest", {12'd0, rf_dest_sel}, 16'd3);
    chk("ldi_data", rf_d, 16'hFFFF);
    chk("ldi_retired", {15'd0, retired}, 16'd1);
    chk("ldi_flags", {13'd0, flag_z, flag_c, flag_n}, 16'd0);
    idle(1);

    step(1, 16'h81FF, 1); idle(3);   // r1 = 0xFFFF
    step(1, 16'h8201, 1); idle(3);   // r2 = 0x0001

    step(1, 16'h1412, 1); idle(2);   // ADD r4,r1,r2
    chk("add_data", rf_d, 16'h0000);
    chk("add_flags", {13'd0, flag_z, flag_c, flag_n}, 16'b110);
    idle(1);

    step(1, 16'h2521, 1); idle(2);   // SUB r5,r2,r1
    chk("sub_data", rf_d, 16'h0002);
    chk("sub_flags", {13'd0, flag_z, flag_c, flag_n}, 16'b010);
    idle(1);

    step(1, 16'hA012, 1); idle(1);   // CMP r1,r2
    chk("cmp_retired", {15'd0, retired}, 16'd1);
    idle(1);
    chk("cmp_ready", {15'd0, instr_ready}, 16'd1);
    chk("cmp_no_write", {15'd0, rf_load_en}, 16'd0);
    chk("cmp_flags", {13'd0, flag_z, flag_c, flag_n}, 16'b001);

    step(1, 16'hF123, 1); idle(1);   // illegal opcode
    chk("ill_pulse", {15'd0, illegal}, 16'd1);
    idle(1);
    chk("ill_flags", {13'd0, flag_z, flag_c, flag_n}, 16'b001);
    chk("ill_ready", {15'd0, instr_ready}, 16'd1);

    // Back-to-back with valid held: LDI r1,5 then SHL r2,r1,r1.
    step(1, 16'h8105, 1);
    for (int i = 0; i < 3; i++) step(1, 16'h6211, 1);
    chk("b2b_ready", {15'd0, instr_ready}, 16'd1);
    step(1, 16'h6211, 1);
    chk("b2b_accept", {15'd0, instr_ready}, 16'd0);
    step(0, 16'h0000, 1); step(0, 16'h0000, 1);
    chk("shl_data", rf_d, 16'h00A0);
    chk("shl_dest", {12'd0, rf_dest_sel}, 16'd2);
    idle(1);

    // Reset during EXEC of ADD.
    step(1, 16'h1412, 1); idle(1);
    step(0, 16'h0000, 0);
    chk("rst_exec_retired", {15'd0, retired}, 16'd0);
    step(0, 16'h0000, 1);
    chk("rst_exec_load_en", {15'd0, rf_load_en}, 16'd0);
    chk("rst_exec_ready", {15'd0, instr_ready}, 16'd1);
    step(1, 16'h8677, 1);
    chk("post_rst_accept", {15'd0, instr_ready}, 16'd0);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 60) != 0);
    end
    idle(5);
    for (int i = 0; i < 16; i++) chk("regfile", rf_mem[i], mreg[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
